// File: rtl/slc3_mem_pkg.sv
// ============================================================================
// Module      : slc3_mem_pkg
// Description : Shared types and constants for the SLC-3 memory access
//               controller (state encoding, datapath word width).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package slc3_mem_pkg;

    localparam int WORD_W = 16;

    // Controller states, explicitly encoded on two bits
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

endpackage : slc3_mem_pkg

`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
// ============================================================================
// Module      : mem_timeout_ctr
// Description : Access watchdog counter. Clears on i_clr, counts while i_en
//               and flags the final permitted ACCESS cycle on o_tc.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_timeout_ctr #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int c_CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

    logic [c_CNT_W-1:0] r_cnt;

    // Count elapsed ACCESS cycles; holds at the terminal value
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != c_LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The count equals TIMEOUT_CYC-1 during the TIMEOUT_CYC-th ACCESS cycle
    assign o_tc = (r_cnt == c_LAST);

endmodule : mem_timeout_ctr

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module      : mem_access_ctrl
// Description : SLC-3 MAR/MDR memory access controller. Loads MAR/MDR from
//               the CPU bus, runs one read or write handshake with memory
//               and pulses Done on completion.
// Options     : MEM_TIMEOUT_EN - when defined, an access without Mem_Ack for
//               TIMEOUT_CYC cycles is aborted and Err is raised.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl
    import slc3_mem_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [WORD_W-1:0] Bus,
    input  logic              LD_MAR,
    input  logic              LD_MDR,
    input  logic              Mem_Req,
    input  logic              Mem_WE,
    input  logic [WORD_W-1:0] Mem_Rdata,
    input  logic              Mem_Ack,
    output logic [WORD_W-1:0] MAR,
    output logic [WORD_W-1:0] MDR,
    output logic [WORD_W-1:0] Mem_Addr,
    output logic [WORD_W-1:0] Mem_Wdata,
    output logic              Mem_CE,
    output logic              Mem_WE_o,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);

    mem_state_t        r_state;
    logic [WORD_W-1:0] r_mar;
    logic [WORD_W-1:0] r_mdr;
    logic              r_op;
    logic              r_ce;
    logic              r_we;
    logic              r_busy;
    logic              r_done;

    logic              w_accept;
    logic              w_timeout;

    // A request is only honoured while idle
    assign w_accept = (r_state == IDLE) && Mem_Req;

`ifdef MEM_TIMEOUT_EN
    logic w_tc;
    logic r_err;

    mem_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout_ctr (
        .clk   (Clk),
        .rst   (~Reset),
        .i_clr (w_accept),
        .i_en  (r_state == ACCESS),
        .o_tc  (w_tc)
    );

    // Abort only when the last permitted cycle passes without an Ack
    assign w_timeout = (r_state == ACCESS) && w_tc && !Mem_Ack;

    // Err is sticky until the next accepted request or reset
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign Err = r_err;
`else
    logic w_unused_cfg;

    // Without the watchdog an access waits for Mem_Ack indefinitely
    assign w_timeout    = 1'b0;
    assign Err          = 1'b0;
    assign w_unused_cfg = (TIMEOUT_CYC == 0);
`endif

    // Access sequencer with registered strobes
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_mar   <= '0;
            r_mdr   <= '0;
            r_op    <= 1'b0;
            r_ce    <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (LD_MAR) r_mar <= Bus;
                    if (LD_MDR) r_mdr <= Bus;
                    if (Mem_Req) begin
                        r_op    <= Mem_WE;
                        r_we    <= Mem_WE;
                        r_ce    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (Mem_Ack || w_timeout) begin
                        // Read data is captured only on a genuine Ack
                        if (Mem_Ack && !r_op) r_mdr <= Mem_Rdata;
                        r_ce    <= 1'b0;
                        r_we    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_ce    <= 1'b0;
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign MAR       = r_mar;
    assign MDR       = r_mdr;
    assign Mem_Addr  = r_mar;
    assign Mem_Wdata = r_mdr;
    assign Mem_CE    = r_ce;
    assign Mem_WE_o  = r_we;
    assign Busy      = r_busy;
    assign Done      = r_done;

endmodule : mem_access_ctrl

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Scoreboard bench for mem_access_ctrl. The driver issues
//               accesses and queues the expected outcome; a monitor checks
//               every ACCESS cycle and each Done pulse against the queue.
// Options     : MEM_TIMEOUT_EN - adds the watchdog abort scenario.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

    localparam int TO_CYC = 4;
`ifdef MEM_TIMEOUT_EN
    localparam int MAX_WAIT = TO_CYC - 1;
`else
    localparam int MAX_WAIT = 6;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] Bus = '0;
    logic        LD_MAR = 1'b0, LD_MDR = 1'b0, Mem_Req = 1'b0, Mem_WE = 1'b0;
    logic [15:0] Mem_Rdata = '0;
    logic        Mem_Ack = 1'b0;
    logic [15:0] MAR, MDR, Mem_Addr, Mem_Wdata;
    logic        Mem_CE, Mem_WE_o, Busy, Done, Err;

    mem_access_ctrl #(.TIMEOUT_CYC(TO_CYC)) dut (
        .Clk(Clk), .Reset(Reset), .Bus(Bus), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
        .Mem_Req(Mem_Req), .Mem_WE(Mem_WE), .Mem_Rdata(Mem_Rdata), .Mem_Ack(Mem_Ack),
        .MAR(MAR), .MDR(MDR), .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata),
        .Mem_CE(Mem_CE), .Mem_WE_o(Mem_WE_o), .Busy(Busy), .Done(Done), .Err(Err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] mdr_after;
        logic        we;
        logic        err;
        int          ce_cycles;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt = 0;
    int          exp_done = 0;
    bit          mon_en = 1'b0;
    logic [15:0] m_mar = '0;
    logic [15:0] m_mdr = '0;

    function automatic void check(string name, logic [15:0] act, logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_quiet();
        LD_MAR = 0; LD_MDR = 0; Mem_Req = 0; Mem_Ack = 0;
        Bus = 16'($urandom); Mem_Rdata = 16'($urandom);
    endtask

    // Bus activity that a busy controller must ignore
    task automatic drive_junk();
        Bus     = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom);
        LD_MAR  = 1'($urandom);
        LD_MDR  = 1'($urandom);
        Mem_Req = 1'($urandom);
        Mem_WE  = 1'($urandom);
    endtask

    // Optional loads, then one access; ack arrives in ACCESS cycle wait_n+1
    task automatic do_access(bit ld_mar, logic [15:0] mar_v, bit ld_mdr, logic [15:0] mdr_v,
                             bit we, int wait_n, logic [15:0] rdata, bit same);
        exp_t e;
        check("idle_before_req", 16'(Busy), 16'd0);
        if (!same) begin
            if (ld_mar) begin drive_quiet(); LD_MAR = 1; Bus = mar_v; step(); end
            if (ld_mdr) begin drive_quiet(); LD_MDR = 1; Bus = mdr_v; step(); end
        end
        if (ld_mar) m_mar = mar_v;
        if (ld_mdr) m_mdr = mdr_v;
        e.addr = m_mar; e.wdata = m_mdr; e.we = we; e.err = 1'b0;
        e.mdr_after = we ? m_mdr : rdata;
        e.ce_cycles = wait_n + 1;
        exp_q.push_back(e);
        exp_done++;
        m_mdr = e.mdr_after;
        drive_quiet();
        if (same) begin
            LD_MAR = ld_mar; LD_MDR = ld_mdr;
            if (ld_mar && ld_mdr) begin
                // one bus value feeds both registers
                Bus = mar_v;
                m_mdr = we ? mar_v : rdata;
                e.wdata = mar_v; e.mdr_after = m_mdr;
                exp_q[$] = e;
            end else begin
                Bus = ld_mar ? mar_v : mdr_v;
            end
        end
        Mem_Req = 1; Mem_WE = we;
        step();
        for (int k = 0; k < wait_n; k++) begin
            drive_junk(); Mem_Ack = 0; Mem_Rdata = 16'($urandom);
            step();
        end
        drive_junk(); Mem_Ack = 1; Mem_Rdata = rdata;
        step();
        drive_junk(); Mem_Ack = 1'($urandom); Mem_Rdata = 16'($urandom);
        step();
        drive_quiet();
    endtask

    // Monitor: per-cycle access checks and Done-time scoreboard pops
    initial begin : monitor
        exp_t e;
        int   ce_cnt = 0;
        int   we_cnt = 0;
        logic prev_done = 1'b0;
        forever begin
            @(negedge Clk);
            if (mon_en) begin
                if (Mem_CE) begin
                    if (exp_q.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL unexpected_access: got Mem_CE=1, required no access");
                    end else begin
                        e = exp_q[0];
                        ce_cnt++;
                        if (Mem_WE_o) we_cnt++;
                        check("mem_addr", Mem_Addr, e.addr);
                        check("mem_wdata", Mem_Wdata, e.wdata);
                        check("mdr_during_access", MDR, e.wdata);
                        check("mem_we_o", 16'(Mem_WE_o), 16'(e.we));
                        check("busy_in_access", 16'(Busy), 16'd1);
                        check("err_in_access", 16'(Err), 16'd0);
                    end
                end
                if (Done) begin
                    check("done_one_cycle", 16'(prev_done), 16'd0);
                    if (exp_q.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL unexpected_done: got Done=1, required none");
                    end else begin
                        e = exp_q.pop_front();
                        check("ce_cycles", 16'(ce_cnt), 16'(e.ce_cycles));
                        check("we_cycles", 16'(we_cnt), e.we ? 16'(e.ce_cycles) : 16'd0);
                        check("mdr_after", MDR, e.mdr_after);
                        check("mar_after", MAR, e.addr);
                        check("err_at_done", 16'(Err), 16'(e.err));
                        check("ce_low_in_done", 16'(Mem_CE), 16'd0);
                        check("busy_in_done", 16'(Busy), 16'd1);
                    end
                    ce_cnt = 0;
                    we_cnt = 0;
                end
            end else begin
                ce_cnt = 0;
                we_cnt = 0;
            end
            if (Done) done_cnt++;
            prev_done = Done;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "simulation time limit");
    end

    initial begin : driver
        int dc0;
        drive_quiet();
        Reset = 0;
        repeat (3) step();
        @(negedge Clk);
        check("rst_mar", MAR, 16'h0000);
        check("rst_mdr", MDR, 16'h0000);
        check("rst_ce", 16'(Mem_CE), 16'd0);
        check("rst_we_o", 16'(Mem_WE_o), 16'd0);
        check("rst_busy", 16'(Busy), 16'd0);
        check("rst_done", 16'(Done), 16'd0);
        check("rst_err", 16'(Err), 16'd0);
        step();
        Reset = 1;
        mon_en = 1;
        step();

        // Read from 3001 acknowledged in the 3rd ACCESS cycle
        do_access(1, 16'h3001, 0, 16'h0000, 0, 2, 16'hBEEF, 0);
        // Write of 1234 to 4000 with a zero-wait Ack
        do_access(1, 16'h4000, 1, 16'h1234, 1, 0, 16'h5A5A, 0);
        // Back-to-back without reloading
        do_access(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0F0F, 0);
        // Loads coincident with the request
        do_access(1, 16'h2222, 1, 16'h2222, 1, 1, 16'h0000, 1);

        for (int i = 0; i < 60; i++) begin
            do_access(1'($urandom), 16'($urandom), 1'($urandom), 16'($urandom),
                      1'($urandom), $urandom_range(0, MAX_WAIT), 16'($urandom),
                      1'($urandom));
            if ($urandom_range(0, 3) == 0) step();
        end

        // Reset asserted in the 2nd ACCESS cycle, Ack afterwards
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
        mon_en = 0;
        dc0 = done_cnt;
        drive_quiet();
        LD_MAR = 1; LD_MDR = 1; Bus = 16'h5555; Mem_Req = 1; Mem_WE = 0;
        step();
        drive_quiet();
        step();
        check("ce_before_reset", 16'(Mem_CE), 16'd1);
        Reset = 0;
        step();
        Reset = 1; Mem_Ack = 1; Mem_Rdata = 16'hDEAD;
        @(negedge Clk);
        check("abort_ce", 16'(Mem_CE), 16'd0);
        check("abort_busy", 16'(Busy), 16'd0);
        check("abort_mar", MAR, 16'h0000);
        check("abort_mdr", MDR, 16'h0000);
        step();
        drive_quiet();
        step();
        check("abort_no_done", 16'(done_cnt - dc0), 16'd0);
        check("abort_mdr_late", MDR, 16'h0000);
        m_mar = '0;
        m_mdr = '0;
        mon_en = 1;
        do_access(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h7E57, 0);

`ifdef MEM_TIMEOUT_EN
        begin : timeout_case
            exp_t e;
            drive_quiet(); LD_MAR = 1; Bus = 16'h6000; step();
            m_mar = 16'h6000;
            e.addr = m_mar; e.wdata = m_mdr; e.mdr_after = m_mdr;
            e.we = 0; e.err = 1; e.ce_cycles = TO_CYC;
            exp_q.push_back(e);
            exp_done++;
            drive_quiet(); Mem_Req = 1; Mem_WE = 0; step();
            for (int k = 0; k < TO_CYC; k++) begin drive_quiet(); step(); end
            drive_quiet(); step();
            for (int k = 0; k < 2; k++) begin
                @(negedge Clk);
                check("err_sticky", 16'(Err), 16'd1);
                check("err_idle_busy", 16'(Busy), 16'd0);
                step();
            end
            // Ack coincident with the final permitted cycle completes normally
            do_access(0, 16'h0000, 0, 16'h0000, 0, TO_CYC - 1, 16'hC0DE, 0);
        end
`endif

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        check("done_pulse_count", 16'(done_cnt), 16'(exp_done));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mem_access_ctrl

`default_nettype wire
